vectored_interrupt_controller: RTL

//   Parametrised multi-channel successor to the single-line interrupt path. Sits in the IF stage

---
 rtl/vectored_interrupt_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller for the IF stage: arbitrates edge-triggered
// request lines and overrides the next PC with a per-channel vector.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   PC_NEXT               next PC from the branch-select mux
//   IRQ                   raw request lines, a rising edge makes a request
//   MASK_WE/MASK_WDATA    channel mask write (1 = channel enabled)
//   GLOBAL_EN             global enable, gates takes only
//   MRET                  return-from-ISR strobe
//   STALL                 pipeline busywait, freezes take/return decisions
//   PC_NEXT_FINAL         PC to load into the PC register
//   INT_TAKEN             pulse in the cycle an interrupt is taken
//   IN_ISR                high while any ISR context is active
//   ACTIVE_ID             channel currently being serviced
//   PENDING               pending request bits
//
// Optional feature macro: VIC_NESTING_EN enables priority preemption with a
// saved-context stack of NEST_DEPTH entries.
module vectored_interrupt_controller #(
    parameter int          NUM_CH     = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4,
    parameter int          NEST_DEPTH = 4,
    localparam int         IDW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC_NEXT,
    input  logic [NUM_CH-1:0] IRQ,
    input  logic              MASK_WE,
    input  logic [NUM_CH-1:0] MASK_WDATA,
    input  logic              GLOBAL_EN,
    input  logic              MRET,
    input  logic              STALL,
    output logic [31:0]       PC_NEXT_FINAL,
    output logic              INT_TAKEN,
    output logic              IN_ISR,
    output logic [IDW-1:0]    ACTIVE_ID,
    output logic [NUM_CH-1:0] PENDING
);

    if (NUM_CH < 1 || NUM_CH > 32 || NEST_DEPTH < 1) begin : g_bad_cfg
        $error("vectored_interrupt_controller: bad parameters");
    end

    typedef enum logic {
        S_IDLE,
        S_ISR
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr;
    logic [IDW-1:0]    active_id;
    logic [IDW-1:0]    winner;
    logic [31:0]       epc;
    logic [31:0]       vec_addr;
    logic              any_elig;
    logic              take;
    logic              ret;

`ifdef VIC_NESTING_EN
    localparam int SPW = $clog2(NEST_DEPTH + 1);
    localparam int SIW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [31:0]    stk_epc [NEST_DEPTH];
    logic [IDW-1:0] stk_id  [NEST_DEPTH];
    logic [SPW-1:0] sp;
    logic [SIW-1:0] push_idx;
    logic [SIW-1:0] pop_idx;

    assign push_idx = SIW'(sp);
    assign pop_idx  = SIW'(sp - SPW'(1));
`endif

    assign eligible = pending & mask;
    assign any_elig = |eligible;
    assign rise     = IRQ & ~irq_q;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
    end

    assign vec_addr = VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);

    // Decisions are suppressed during reset so no stray vector or pulse
    // escapes while the state is being cleared.
    always_comb begin
        take = 1'b0;
        ret  = 1'b0;
        if (!RESET && !STALL) begin
            if (state == S_IDLE) begin
                take = GLOBAL_EN && any_elig && !MRET;
            end else begin
                ret = MRET;
`ifdef VIC_NESTING_EN
                take = !MRET && GLOBAL_EN && any_elig &&
                       (winner < active_id) &&
                       (sp < SPW'(NEST_DEPTH));
`endif
            end
        end
    end

    assign clr = take ? (NUM_CH'(1) << winner) : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            irq_q     <= '0;
            mask      <= '0;
            pending   <= '0;
            active_id <= '0;
            epc       <= '0;
`ifdef VIC_NESTING_EN
            sp        <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_epc[i] <= '0;
                stk_id[i]  <= '0;
            end
`endif
        end else begin
            irq_q <= IRQ;
            if (MASK_WE) begin
                mask <= MASK_WDATA;
            end
            // A new edge on the bit being cleared re-arms it.
            pending <= (pending & ~clr) | rise;
            if (take) begin
`ifdef VIC_NESTING_EN
                if (state == S_ISR) begin
                    stk_epc[push_idx] <= epc;
                    stk_id[push_idx]  <= active_id;
                    sp                <= sp + SPW'(1);
                end
`endif
                epc       <= PC_NEXT;
                active_id <= winner;
                state     <= S_ISR;
            end else if (ret) begin
`ifdef VIC_NESTING_EN
                if (sp != '0) begin
                    epc       <= stk_epc[pop_idx];
                    active_id <= stk_id[pop_idx];
                    sp        <= sp - SPW'(1);
                end else begin
                    state <= S_IDLE;
                end
`else
                state <= S_IDLE;
`endif
            end
        end
    end

    assign PC_NEXT_FINAL = take ? vec_addr :
                           ret  ? epc      : PC_NEXT;
    assign INT_TAKEN     = take;
    assign IN_ISR        = (state == S_ISR);
    assign ACTIVE_ID     = active_id;
    assign PENDING       = pending;

endmodule
